// File: rtl/rgen_pkg.sv
// Shared types and constants for the random request generator.
package rgen_pkg;

  localparam int          LFSR_W     = 32;
  localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;  // x^32+x^22+x^2+x+1, right-shift Galois taps
  localparam int          ROT_STRIDE = 7;

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    DONE
  } rgen_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {1'b0, v[LFSR_W-1:1]} ^ (v[0] ? LFSR_POLY : '0);
  endfunction

  function automatic logic [LFSR_W-1:0] rotl32(input logic [LFSR_W-1:0] v, input int unsigned n);
    int unsigned s;
    s = n % LFSR_W;
    if (s == 0) return v;
    return (v << s) | (v >> (LFSR_W - s));
  endfunction

endpackage

// File: rtl/lfsr32.sv
// Free-running 32-bit Galois LFSR shared by all request channels.
module lfsr32
  import rgen_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1ACE_B00C
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] value
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) value <= SEED;
    else        value <= lfsr_next(value);
  end

endmodule

// File: rtl/random_req_gen.sv
// Randomised valid/ready request generator: per-channel draw, burst, accept
// counting and limit/done handling, all fed from one shared LFSR.
//
// state | meaning
// IDLE  | no request pending; draws each cycle while enabled
// OFFER | valid high, bits frozen until accepted
// DONE  | accept limit reached; parked until cfg_clr or reset
module random_req_gen
  import rgen_pkg::*;
#(
  parameter int          CH        = 2,
  parameter int          DW        = 8,
  parameter int          TW        = 10,
  parameter int          CW        = 16,
  parameter int          BURST_LEN = 4,
  parameter logic [31:0] SEED      = 32'h1ACE_B00C
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CH-1:0]    cfg_en,
  input  logic [CH*TW-1:0] cfg_vld_thr,
  input  logic             cfg_burst,
  input  logic [CH*CW-1:0] cfg_limit,
  input  logic             cfg_clr,
  input  logic [CH-1:0]    io_enq_ready,
  output logic [CH-1:0]    io_enq_valid,
  output logic [CH*DW-1:0] io_enq_bits,
  output logic [CH*CW-1:0] acc_cnt,
  output logic [CH-1:0]    done
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] BURST_RELOAD = BW'(BURST_LEN - 1);

  if (DW + TW > LFSR_W) begin : g_bad_width
    $error("random_req_gen: DW+TW must not exceed 32");
  end
  if (BURST_LEN < 1) begin : g_bad_burst
    $error("random_req_gen: BURST_LEN must be at least 1");
  end
  if (SEED == 32'h0) begin : g_bad_seed
    $error("random_req_gen: SEED must be non-zero");
  end

  logic [31:0] lfsr_q;

  lfsr32 #(.SEED(SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .value (lfsr_q)
  );

  for (genvar c = 0; c < CH; c++) begin : g_ch
    localparam int unsigned ROT = (ROT_STRIDE * c) % LFSR_W;

    rgen_state_e      state_q;
    logic             valid_q;
    logic [DW-1:0]    bits_q;
    logic [CW-1:0]    cnt_q;
    logic             done_q;
    logic [BW-1:0]    burst_left_q;

    logic [TW+DW-1:0] win;
    logic [TW-1:0]    thr;
    logic [CW-1:0]    lim;
    logic [DW-1:0]    pay;
    logic             draw;
    logic             accept;
    logic [CW:0]      cnt_p1;
    logic             lim_hit;
    logic [CW-1:0]    cnt_inc;
    logic [BW-1:0]    reload;

    assign win     = (TW + DW)'(rotl32(lfsr_q, ROT));
    assign thr     = cfg_vld_thr[c*TW +: TW];
    assign lim     = cfg_limit[c*CW +: CW];
    assign pay     = win[TW +: DW];
    assign draw    = cfg_en[c] && (win[TW-1:0] < thr);
    assign accept  = valid_q && io_enq_ready[c];
    assign cnt_p1  = {1'b0, cnt_q} + (CW + 1)'(1);
    // >= rather than == so a limit lowered below the running count still stops the channel
    assign lim_hit = (lim != '0) && (cnt_p1 >= {1'b0, lim});
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
    assign reload  = cfg_burst ? BURST_RELOAD : '0;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state_q      <= IDLE;
        valid_q      <= 1'b0;
        bits_q       <= '0;
        cnt_q        <= '0;
        done_q       <= 1'b0;
        burst_left_q <= '0;
      end else begin
        if (cfg_clr) begin
          cnt_q  <= '0;
          done_q <= 1'b0;
        end
        case (state_q)
          IDLE: begin
            if (draw) begin
              state_q      <= OFFER;
              valid_q      <= 1'b1;
              bits_q       <= pay;
              burst_left_q <= reload;
            end
          end
          OFFER: begin
            // a clear on the accepting edge wins: count stays 0 and the limit is not applied
            if (accept) begin
              if (!cfg_clr) cnt_q <= cnt_inc;
              if (lim_hit && !cfg_clr) begin
                state_q <= DONE;
                valid_q <= 1'b0;
                done_q  <= 1'b1;
              end else if (burst_left_q != '0) begin
                bits_q       <= pay;
                burst_left_q <= burst_left_q - BW'(1);
              end else if (draw) begin
                bits_q       <= pay;
                burst_left_q <= reload;
              end else begin
                state_q <= IDLE;
                valid_q <= 1'b0;
              end
            end
          end
          DONE: begin
            if (cfg_clr) state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        endcase
      end
    end

    assign io_enq_valid[c]          = valid_q;
    assign io_enq_bits[c*DW +: DW]  = bits_q;
    assign acc_cnt[c*CW +: CW]      = cnt_q;
    assign done[c]                  = done_q;
  end

endmodule

// File: tb/tb_random_req_gen.sv
// Scoreboard bench for random_req_gen: a cycle-level reference model queues the
// expected outputs, a monitor pops and compares them every cycle.
module tb_random_req_gen;

  localparam int          CH   = 2;
  localparam int          DW   = 8;
  localparam int          TW   = 10;
  localparam int          CW   = 4;
  localparam int          BL   = 4;
  localparam logic [31:0] SEED = 32'h1ACE_B00C;
  localparam int          CMAX = (1 << CW) - 1;

  logic             clock;
  logic             reset;
  logic [CH-1:0]    cfg_en;
  logic [CH*TW-1:0] cfg_vld_thr;
  logic             cfg_burst;
  logic [CH*CW-1:0] cfg_limit;
  logic             cfg_clr;
  logic [CH-1:0]    io_enq_ready;
  logic [CH-1:0]    io_enq_valid;
  logic [CH*DW-1:0] io_enq_bits;
  logic [CH*CW-1:0] acc_cnt;
  logic [CH-1:0]    done;

  random_req_gen #(
    .CH(CH), .DW(DW), .TW(TW), .CW(CW), .BURST_LEN(BL), .SEED(SEED)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cfg_en       (cfg_en),
    .cfg_vld_thr  (cfg_vld_thr),
    .cfg_burst    (cfg_burst),
    .cfg_limit    (cfg_limit),
    .cfg_clr      (cfg_clr),
    .io_enq_ready (io_enq_ready),
    .io_enq_valid (io_enq_valid),
    .io_enq_bits  (io_enq_bits),
    .acc_cnt      (acc_cnt),
    .done         (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic          v;
    logic [DW-1:0] b;
    logic [CW-1:0] cnt;
    logic          d;
  } exp_t;

  exp_t exp_q[CH][$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s ch%0d: got %0h expected %0h (t=%0t)", name, c, act, exp, $time);
  endtask

  // Reference model: channel mode 0=idle 1=offering 2=parked at limit
  int          m_mode[CH];
  int          m_bits[CH];
  int          m_burst[CH];
  int          m_cnt[CH];
  bit   [31:0] m_lfsr;

  function automatic bit [31:0] rotl(input bit [31:0] v, input int n);
    if (n == 0) return v;
    return (v << n) | (v >> (32 - n));
  endfunction

  task automatic model_step();
    exp_t e;
    if (reset !== 1'b1) begin
      m_lfsr = SEED;
      for (int c = 0; c < CH; c++) begin
        m_mode[c] = 0; m_bits[c] = 0; m_burst[c] = 0; m_cnt[c] = 0;
      end
    end
    for (int c = 0; c < CH; c++) begin
      e.v   = (m_mode[c] == 1);
      e.b   = DW'(m_bits[c]);
      e.cnt = CW'(m_cnt[c]);
      e.d   = (m_mode[c] == 2);
      exp_q[c].push_back(e);
    end
    if (reset !== 1'b1) return;
    for (int c = 0; c < CH; c++) begin
      bit [31:0] r;
      int lo, pay, thr, lim;
      bit draw, acc, hit;
      r    = rotl(m_lfsr, 7 * c);
      lo   = int'(r % (1 << TW));
      pay  = int'((r >> TW) % (1 << DW));
      thr  = int'(cfg_vld_thr[c*TW +: TW]);
      lim  = int'(cfg_limit[c*CW +: CW]);
      draw = cfg_en[c] && (lo < thr);
      acc  = (m_mode[c] == 1) && io_enq_ready[c];
      if (cfg_clr) m_cnt[c] = 0;
      case (m_mode[c])
        0: if (draw) begin
             m_mode[c] = 1; m_bits[c] = pay; m_burst[c] = cfg_burst ? BL - 1 : 0;
           end
        1: if (acc) begin
             hit = !cfg_clr && (lim != 0) && (m_cnt[c] + 1 >= lim);
             if (!cfg_clr) m_cnt[c] = (m_cnt[c] >= CMAX) ? CMAX : m_cnt[c] + 1;
             if (hit) m_mode[c] = 2;
             else if (m_burst[c] > 0) begin m_bits[c] = pay; m_burst[c]--; end
             else if (draw) begin m_bits[c] = pay; m_burst[c] = cfg_burst ? BL - 1 : 0; end
             else m_mode[c] = 0;
           end
        default: if (cfg_clr) m_mode[c] = 0;
      endcase
    end
    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
  endtask

  initial begin
    forever begin
      @(negedge clock);
      model_step();
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      for (int c = 0; c < CH; c++) begin
        if (exp_q[c].size() == 0) begin
          chk("sb_empty", c, 32'd0, 32'd1);
        end else begin
          e = exp_q[c].pop_front();
          chk("valid", c, 32'(io_enq_valid[c]), 32'(e.v));
          if (e.v) chk("bits", c, 32'(io_enq_bits[c*DW +: DW]), 32'(e.b));
          chk("acc_cnt", c, 32'(acc_cnt[c*CW +: CW]), 32'(e.cnt));
          chk("done", c, 32'(done[c]), 32'(e.d));
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_thr(input int t0, input int t1);
    cfg_vld_thr = {TW'(t1), TW'(t0)};
  endtask

  task automatic pulse_clr();
    cfg_clr = 1'b1;
    step();
    cfg_clr = 1'b0;
  endtask

  task automatic wait_valid(input int c, input int budget, output bit ok);
    ok = io_enq_valid[c];
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      ok = io_enq_valid[c];
    end
  endtask

  function automatic int pick_thr();
    case ($urandom % 5)
      0:       return 0;
      1:       return 1;
      2:       return 100;
      3:       return 1023;
      default: return int'($urandom % 1024);
    endcase
  endfunction

  initial begin
    bit ok;
    int cnt;
    logic [DW-1:0] b0;

    reset        = 1'b0;
    cfg_en       = 2'b11;
    cfg_burst    = 1'b0;
    cfg_limit    = '0;
    cfg_clr      = 1'b0;
    io_enq_ready = 2'b11;
    set_thr(0, 1023);
    step(3);
    chk("rst_valid", 0, 32'(io_enq_valid), 32'd0);
    chk("rst_acc_cnt", 0, 32'(acc_cnt), 32'd0);
    reset = 1'b1;

    // thr=0 never offers; thr=1023 offers at once and keeps counting to saturation
    ok = 1'b0;
    for (int i = 0; i < 2 && !ok; i++) begin
      step();
      ok = io_enq_valid[1];
    end
    chk("ch1_valid_within_2", 1, 32'(ok), 32'd1);
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (io_enq_valid[0]) cnt++;
    end
    chk("ch0_thr0_valid_cycles", 0, cnt, 0);
    chk("ch1_saturated_cnt", 1, 32'(acc_cnt[CW +: CW]), CMAX);

    // stall: valid and bits must hold across 20 unready cycles while cfg_en toggles
    io_enq_ready = 2'b00;
    set_thr(1023, 1023);
    pulse_clr();
    wait_valid(0, 5, ok);
    chk("hold_valid_rise", 0, 32'(ok), 32'd1);
    b0 = io_enq_bits[DW-1:0];
    for (int i = 0; i < 20; i++) begin
      cfg_en = ~cfg_en;
      step();
      chk("hold_valid", 0, 32'(io_enq_valid[0]), 32'd1);
      chk("hold_bits", 0, 32'(io_enq_bits[DW-1:0]), 32'(b0));
    end
    cfg_en       = 2'b11;
    io_enq_ready = 2'b01;
    step();
    io_enq_ready = 2'b00;
    chk("hold_first_ready_accept", 0, 32'(acc_cnt[CW-1:0]), 32'd1);

    // burst: one rare draw yields BL back-to-back beats
    cfg_burst    = 1'b1;
    set_thr(1, 1);
    io_enq_ready = 2'b11;
    step(3);
    pulse_clr();
    wait_valid(0, 8000, ok);
    chk("burst_start", 0, 32'(ok), 32'd1);
    for (int j = 0; j < BL; j++) begin
      chk("burst_no_bubble", 0, 32'(io_enq_valid[0]), 32'd1);
      step();
    end
    chk("burst_cnt", 0, 32'(acc_cnt[CW-1:0]), BL);

    // accept limit, clear and resume, then a limit lowered under the count
    cfg_burst = 1'b0;
    set_thr(1023, 1023);
    cfg_limit = {CW'(0), CW'(5)};
    pulse_clr();
    step(20);
    chk("limit_cnt", 0, 32'(acc_cnt[CW-1:0]), 32'd5);
    chk("limit_done", 0, 32'(done[0]), 32'd1);
    chk("limit_valid_low", 0, 32'(io_enq_valid[0]), 32'd0);
    pulse_clr();
    chk("clr_cnt", 0, 32'(acc_cnt[CW-1:0]), 32'd0);
    chk("clr_done", 0, 32'(done[0]), 32'd0);
    step(10);
    chk("clr_traffic_resumes", 0, 32'(acc_cnt[CW-1:0] > 0), 32'd1);
    cfg_limit[CW +: CW] = CW'(3);
    step(2);
    chk("lowered_limit_done", 1, 32'(done[1]), 32'd1);

    // probability: thr=100 gives ~9.8% valid cycles
    cfg_limit = '0;
    set_thr(100, 100);
    pulse_clr();
    cnt = 0;
    for (int i = 0; i < 10000; i++) begin
      step();
      if (io_enq_valid[0]) cnt++;
    end
    chk("valid_rate_in_window", 0, 32'(cnt >= 830 && cnt <= 1130), 32'd1);

    // asynchronous reset while offering; model follows the reseeded sequence afterwards
    set_thr(1023, 1023);
    io_enq_ready = 2'b00;
    wait_valid(0, 5, ok);
    chk("pre_reset_valid", 0, 32'(ok), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_reset_valid", 0, 32'(io_enq_valid), 32'd0);
    chk("async_reset_bits", 0, 32'(io_enq_bits), 32'd0);
    step(2);
    reset        = 1'b1;
    io_enq_ready = 2'b11;
    step(5);

    // randomized mix of every control
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        set_thr(pick_thr(), pick_thr());
        cfg_burst = 1'($urandom % 2);
      end
      if (i % 97 == 0) cfg_limit = CH*CW'($urandom);
      cfg_en       = ($urandom % 5 == 0) ? CH'($urandom) : {CH{1'b1}};
      io_enq_ready = CH'($urandom);
      cfg_clr      = ($urandom % 32 == 0);
      step();
    end
    cfg_clr = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
